// File: rtl/exe_pkg.sv
// Shared definitions for the RV32IM execute stage: operation codes,
// datapath widths and the divider FSM encoding.
package exe_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

endpackage

// File: rtl/execute_stage_iter_divider.sv
// Iterative radix-2 restoring divider with single-cycle handling of the
// divide-by-zero and signed-overflow cases.
module iter_divider
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic            signed_i,
    input  logic            rem_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output div_state_e      state_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    // Handshake: start_i is sampled only in IDLE and must stay stable while
    // stall_o is high; done_o pulses for exactly the cycle result_o is valid.
    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] int_min;

    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, dvsr_q};
        step_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};

        abs_a    = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
        abs_b    = (signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
        int_min  = {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (divisor_i == '0);
        overflow = signed_i && (dividend_i == int_min) && (divisor_i == '1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        result_o  = '0;

        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    if (div_zero) begin
                        done_o   = 1'b1;
                        result_o = rem_i ? dividend_i : '1;
                    end else if (overflow) begin
                        done_o   = 1'b1;
                        result_o = rem_i ? '0 : int_min;
                    end else begin
                        stall_o   = 1'b1;
                        state_d   = BUSY;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = abs_a;
                        dvsr_d    = abs_b;
                        neg_quo_d = signed_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_rem_d = signed_i && dividend_i[XLEN-1];
                        is_rem_d  = rem_i;
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        done_o   = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                        if (is_rem_q) result_o = neg_rem_q ? -step_rem : step_rem;
                        else          result_o = neg_quo_q ? -step_quo : step_quo;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU and multiplier, iterative divider,
// and the EX/MEM pipeline register feeding the memory-access stage.
module execute_stage
    import exe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_id_exe,
    input  logic [XLEN-1:0]       op_a_id_exe,
    input  logic [XLEN-1:0]       op_b_id_exe,
    input  logic [4:0]            alu_op_id_exe,
    input  logic [XLEN-1:0]       w_data_id_exe,
    input  logic [REG_ADDR_W-1:0] write_reg_id_exe,
    input  logic                  mem_read_id_exe,
    input  logic                  mem_write_id_exe,
    input  logic                  mem_to_reg_id_exe,
    input  logic                  flush_exe,
    output logic                  stall_exe,
    output logic [XLEN-1:0]       alu_out_exe_mem,
    output logic [XLEN-1:0]       w_data_exe_mem,
    output logic [REG_ADDR_W-1:0] write_reg_exe_mem,
    output logic                  mem_read_exe_mem,
    output logic                  mem_write_exe_mem,
    output logic                  mem_to_reg_exe_mem
);

    logic [XLEN-1:0]       alu_out_q, alu_out_d;
    logic [XLEN-1:0]       w_data_q, w_data_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;

    logic [XLEN-1:0]       hold_w_data_q, hold_w_data_d;
    logic [REG_ADDR_W-1:0] hold_write_reg_q, hold_write_reg_d;
    logic                  hold_mem_read_q, hold_mem_read_d;
    logic                  hold_mem_write_q, hold_mem_write_d;
    logic                  hold_mem_to_reg_q, hold_mem_to_reg_d;

    logic                  is_div;
    logic                  div_signed;
    logic                  div_rem;
    logic                  div_stall;
    logic                  div_done;
    logic [XLEN-1:0]       div_result;
    div_state_e            div_state;

    logic [4:0]            shamt;
    logic                  mul_a_signed;
    logic                  mul_b_signed;
    logic [2*XLEN-1:0]     mul_a_ext;
    logic [2*XLEN-1:0]     mul_b_ext;
    logic [2*XLEN-1:0]     product;
    logic [XLEN-1:0]       alu_res;

    always_comb begin
        is_div     = (alu_op_id_exe >= ALU_DIV) && (alu_op_id_exe <= ALU_REMU);
        div_signed = (alu_op_id_exe == ALU_DIV) || (alu_op_id_exe == ALU_REM);
        div_rem    = (alu_op_id_exe == ALU_REM) || (alu_op_id_exe == ALU_REMU);
    end

    iter_divider #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (valid_id_exe && is_div),
        .flush_i    (flush_exe),
        .signed_i   (div_signed),
        .rem_i      (div_rem),
        .dividend_i (op_a_id_exe),
        .divisor_i  (op_b_id_exe),
        .stall_o    (div_stall),
        .done_o     (div_done),
        .result_o   (div_result),
        .state_o    (div_state)
    );

    // One shared multiplier: operands are sign- or zero-extended to 2*XLEN,
    // which keeps every MULH variant exact in the low 2*XLEN product bits.
    always_comb begin
        mul_a_signed = (alu_op_id_exe == ALU_MULH) || (alu_op_id_exe == ALU_MULHSU);
        mul_b_signed = (alu_op_id_exe == ALU_MULH);
        mul_a_ext    = {{XLEN{mul_a_signed && op_a_id_exe[XLEN-1]}}, op_a_id_exe};
        mul_b_ext    = {{XLEN{mul_b_signed && op_b_id_exe[XLEN-1]}}, op_b_id_exe};
        product      = mul_a_ext * mul_b_ext;
        shamt        = op_b_id_exe[4:0];

        alu_res = '0;
        case (alu_op_id_exe)
            ALU_ADD:    alu_res = op_a_id_exe + op_b_id_exe;
            ALU_SUB:    alu_res = op_a_id_exe - op_b_id_exe;
            ALU_SLL:    alu_res = op_a_id_exe << shamt;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a_id_exe) < $signed(op_b_id_exe)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a_id_exe < op_b_id_exe};
            ALU_XOR:    alu_res = op_a_id_exe ^ op_b_id_exe;
            ALU_SRL:    alu_res = op_a_id_exe >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(op_a_id_exe) >>> shamt);
            ALU_OR:     alu_res = op_a_id_exe | op_b_id_exe;
            ALU_AND:    alu_res = op_a_id_exe & op_b_id_exe;
            ALU_PASSB:  alu_res = op_b_id_exe;
            ALU_MUL:    alu_res = product[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_res = product[2*XLEN-1:XLEN];
            default:    alu_res = '0;
        endcase
    end

    // Control fields of a long divide are captured on entry so its write-back
    // does not depend on the front end still presenting the instruction.
    always_comb begin
        hold_w_data_d     = hold_w_data_q;
        hold_write_reg_d  = hold_write_reg_q;
        hold_mem_read_d   = hold_mem_read_q;
        hold_mem_write_d  = hold_mem_write_q;
        hold_mem_to_reg_d = hold_mem_to_reg_q;
        if (div_stall && (div_state == IDLE)) begin
            hold_w_data_d     = w_data_id_exe;
            hold_write_reg_d  = write_reg_id_exe;
            hold_mem_read_d   = mem_read_id_exe;
            hold_mem_write_d  = mem_write_id_exe;
            hold_mem_to_reg_d = mem_to_reg_id_exe;
        end
    end

    always_comb begin
        alu_out_d    = '0;
        w_data_d     = '0;
        write_reg_d  = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;

        if (flush_exe) begin
            alu_out_d = '0;
        end else if (div_state == BUSY) begin
            if (div_done) begin
                alu_out_d    = div_result;
                w_data_d     = hold_w_data_q;
                write_reg_d  = hold_write_reg_q;
                mem_read_d   = hold_mem_read_q;
                mem_write_d  = hold_mem_write_q;
                mem_to_reg_d = hold_mem_to_reg_q;
            end
        end else if (valid_id_exe && (!is_div || div_done)) begin
            alu_out_d    = is_div ? div_result : alu_res;
            w_data_d     = w_data_id_exe;
            write_reg_d  = write_reg_id_exe;
            mem_read_d   = mem_read_id_exe;
            mem_write_d  = mem_write_id_exe;
            mem_to_reg_d = mem_to_reg_id_exe;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q         <= '0;
            w_data_q          <= '0;
            write_reg_q       <= '0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_to_reg_q      <= 1'b0;
            hold_w_data_q     <= '0;
            hold_write_reg_q  <= '0;
            hold_mem_read_q   <= 1'b0;
            hold_mem_write_q  <= 1'b0;
            hold_mem_to_reg_q <= 1'b0;
        end else begin
            alu_out_q         <= alu_out_d;
            w_data_q          <= w_data_d;
            write_reg_q       <= write_reg_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            mem_to_reg_q      <= mem_to_reg_d;
            hold_w_data_q     <= hold_w_data_d;
            hold_write_reg_q  <= hold_write_reg_d;
            hold_mem_read_q   <= hold_mem_read_d;
            hold_mem_write_q  <= hold_mem_write_d;
            hold_mem_to_reg_q <= hold_mem_to_reg_d;
        end
    end

    assign stall_exe          = div_stall;
    assign alu_out_exe_mem    = alu_out_q;
    assign w_data_exe_mem     = w_data_q;
    assign write_reg_exe_mem  = write_reg_q;
    assign mem_read_exe_mem   = mem_read_q;
    assign mem_write_exe_mem  = mem_write_q;
    assign mem_to_reg_exe_mem = mem_to_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, multiply, divide timing, divide
// special cases and flush of an in-flight divide.
module tb_execute_stage;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id_exe;
    logic [31:0] op_a_id_exe;
    logic [31:0] op_b_id_exe;
    logic [4:0]  alu_op_id_exe;
    logic [31:0] w_data_id_exe;
    logic [4:0]  write_reg_id_exe;
    logic        mem_read_id_exe;
    logic        mem_write_id_exe;
    logic        mem_to_reg_id_exe;
    logic        flush_exe;
    logic        stall_exe;
    logic [31:0] alu_out_exe_mem;
    logic [31:0] w_data_exe_mem;
    logic [4:0]  write_reg_exe_mem;
    logic        mem_read_exe_mem;
    logic        mem_write_exe_mem;
    logic        mem_to_reg_exe_mem;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_id_exe       (valid_id_exe),
        .op_a_id_exe        (op_a_id_exe),
        .op_b_id_exe        (op_b_id_exe),
        .alu_op_id_exe      (alu_op_id_exe),
        .w_data_id_exe      (w_data_id_exe),
        .write_reg_id_exe   (write_reg_id_exe),
        .mem_read_id_exe    (mem_read_id_exe),
        .mem_write_id_exe   (mem_write_id_exe),
        .mem_to_reg_id_exe  (mem_to_reg_id_exe),
        .flush_exe          (flush_exe),
        .stall_exe          (stall_exe),
        .alu_out_exe_mem    (alu_out_exe_mem),
        .w_data_exe_mem     (w_data_exe_mem),
        .write_reg_exe_mem  (write_reg_exe_mem),
        .mem_read_exe_mem   (mem_read_exe_mem),
        .mem_write_exe_mem  (mem_write_exe_mem),
        .mem_to_reg_exe_mem (mem_to_reg_exe_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] wd, input logic [4:0] wr,
                         input logic mr, input logic mw, input logic mtr);
        valid_id_exe      = 1'b1;
        alu_op_id_exe     = op;
        op_a_id_exe       = a;
        op_b_id_exe       = b;
        w_data_id_exe     = wd;
        write_reg_id_exe  = wr;
        mem_read_id_exe   = mr;
        mem_write_id_exe  = mw;
        mem_to_reg_id_exe = mtr;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        check(tag, alu_out_exe_mem, exp);
    endtask

    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wr,
                           input logic [31:0] exp, input int exp_stalls);
        int nst;
        logic bubble_bad;
        nst = 0;
        bubble_bad = 1'b0;
        drive(op, a, b, 32'h0, wr, 1'b0, 1'b0, 1'b0);
        #1;
        while (stall_exe && nst < 40) begin
            nst++;
            tick();
            if (alu_out_exe_mem !== 32'h0 || write_reg_exe_mem !== 5'd0) bubble_bad = 1'b1;
        end
        check({tag, " stall cycles"}, nst, exp_stalls);
        check({tag, " bubbles"}, {31'b0, bubble_bad}, 32'h0);
        tick();
        check({tag, " result"}, alu_out_exe_mem, exp);
        check({tag, " rd"}, {27'b0, write_reg_exe_mem}, {27'b0, wr});
        valid_id_exe = 1'b0;
    endtask

    initial begin
        logic stale_seen;

        rst_n     = 1'b0;
        flush_exe = 1'b0;
        drive(ALU_ADD, 32'h5, 32'h6, 32'h77, 5'd9, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("reset alu_out", alu_out_exe_mem, 32'h0);
        check("reset w_data", w_data_exe_mem, 32'h0);
        check("reset write_reg", {27'b0, write_reg_exe_mem}, 32'h0);
        check("reset mem_read", {31'b0, mem_read_exe_mem}, 32'h0);
        check("reset mem_write", {31'b0, mem_write_exe_mem}, 32'h0);
        check("reset mem_to_reg", {31'b0, mem_to_reg_exe_mem}, 32'h0);
        check("reset stall", {31'b0, stall_exe}, 32'h0);
        rst_n = 1'b1;

        drive(ALU_ADD, 32'h100, 32'h24, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("add alu_out", alu_out_exe_mem, 32'h124);
        check("add w_data", w_data_exe_mem, 32'hDEADBEEF);
        check("add mem_write", {31'b0, mem_write_exe_mem}, 32'h1);

        valid_id_exe = 1'b0;
        tick();
        check("invalid bubble", alu_out_exe_mem, 32'h0);

        run_alu("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFFFFFE);
        run_alu("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
        run_alu("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_alu("sra", ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000);
        run_alu("sll shamt", ALU_SLL, 32'd1, 32'h21, 32'd2);
        run_alu("mul", ALU_MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
        run_alu("mulh", ALU_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
        run_alu("mulhu", ALU_MULHU, 32'h80000000, 32'h80000000, 32'h40000000);
        run_alu("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        run_alu("mulhu max", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

        run_div("div", ALU_DIV, 32'hFFFFFF9C, 32'd7, 5'd5, 32'hFFFFFFF2, 32);
        run_div("rem", ALU_REM, 32'hFFFFFF9C, 32'd7, 5'd5, 32'hFFFFFFFE, 32);
        run_div("divu", ALU_DIVU, 32'd1000, 32'd3, 5'd6, 32'd333, 32);
        run_div("remu", ALU_REMU, 32'd1000, 32'd3, 5'd6, 32'd1, 32);
        run_div("div neg divisor", ALU_DIV, 32'd100, 32'hFFFFFFF9, 5'd4, 32'hFFFFFFF2, 32);
        run_div("divu by zero", ALU_DIVU, 32'h1234, 32'h0, 5'd3, 32'hFFFFFFFF, 0);
        run_div("remu by zero", ALU_REMU, 32'h1234, 32'h0, 5'd3, 32'h1234, 0);
        run_div("div overflow", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, 0);
        run_div("rem overflow", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h0, 0);

        drive(ALU_DIVU, 32'd1000, 32'd3, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("flush pre stall", {31'b0, stall_exe}, 32'h1);
        flush_exe = 1'b1;
        #1;
        check("flush stall drop", {31'b0, stall_exe}, 32'h0);
        tick();
        check("flush bubble alu", alu_out_exe_mem, 32'h0);
        check("flush bubble rd", {27'b0, write_reg_exe_mem}, 32'h0);
        flush_exe = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0);
        #1;
        check("post flush stall", {31'b0, stall_exe}, 32'h0);
        tick();
        check("post flush add", alu_out_exe_mem, 32'd2);
        check("post flush rd", {27'b0, write_reg_exe_mem}, 32'd3);
        valid_id_exe = 1'b0;
        stale_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (alu_out_exe_mem !== 32'h0 || stall_exe !== 1'b0) stale_seen = 1'b1;
        end
        check("no stale quotient", {31'b0, stale_seen}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32IM execute stage plus EX/MEM pipeline register. It sits directly upstream of the memory-access stage and drives its `*_exe_mem` inputs.
- Computes ALU and multiply results in a single cycle. Performs DIV/DIVU/REM/REMU with an iterative radix-2 divider that stalls the front end.
- Inserts bubbles into EX/MEM while a divide is in flight.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid_id_exe  in  1  ID/EX holds a live instruction
- op_a_id_exe  in  XLEN  operand A (rs1 or PC)
- op_b_id_exe  in  XLEN  operand B (rs2 or immediate)
- alu_op_id_exe  in  5  operation code, from the package
- w_data_id_exe  in  XLEN  rs2 value for stores
- write_reg_id_exe  in  REG_ADDR_W  destination register
- mem_read_id_exe / mem_write_id_exe / mem_to_reg_id_exe  in  1 each  memory controls
- flush_exe  in  1  kill the instruction in EX (branch redirect)
- stall_exe  out  1  front end must hold IF/ID/EX inputs stable
- alu_out_exe_mem  out  XLEN  result / memory address
- w_data_exe_mem  out  XLEN  store data
- write_reg_exe_mem  out  REG_ADDR_W  destination
- mem_read_exe_mem / mem_write_exe_mem / mem_to_reg_exe_mem  out  1 each

Behaviour:
- Reset, and the bubble encoding:
  - All EX/MEM outputs are reset to 0.
  - FSM goes to IDLE, counter to 0, stall_exe to 0.
  - A bubble is all-zero EX/MEM fields; x0 as destination makes it a no-op.
- Non-divide ops (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND PASSB MUL MULH MULHSU MULHU):
  - Result is registered into EX/MEM at the edge ending the cycle the op is presented; latency is 1.
  - Shift amounts use op_b[4:0].
  - MULH* take the upper 32 bits of the 64-bit product with the correct signedness per variant.
- If valid_id_exe = 0, the next EX/MEM value is a bubble.
- FSM states: IDLE, BUSY.
- IDLE, divide op, valid, divisor != 0, and not the signed overflow case:
  - stall_exe = 1 combinationally.
  - At the edge: latch magnitudes and sign flags, counter = 0, go to BUSY, EX/MEM gets a bubble.
- BUSY:
  - One restoring-division step per cycle.
  - stall_exe = 1 while counter < 31; counter increments each cycle.
  - At counter == 31: stall_exe = 0; final quotient or remainder is sign-corrected and registered into EX/MEM with the held control fields; go to IDLE.
  - Total: 33 cycles occupancy, 32 stall cycles.
- Divide special cases resolve in 1 cycle with no stall:
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Signed rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- flush_exe = 1 has priority over everything except reset:
  - stall_exe is forced to 0.
  - EX/MEM gets a bubble at the edge.
  - FSM goes to IDLE, abandoning any divide.
- Reset mid-divide: aborts, same as reset.
- While stall_exe = 1, ID/EX inputs are held stable by upstream. Only the operands latched at entry are used, so input changes in BUSY are ignored.
- A back-to-back divide starts only once the FSM is back in IDLE, i.e. the cycle after completion.

Decomposition:
- Package exe_pkg holds:
  - the 5-bit alu_op localparams (ALU_ADD = 0 … ALU_PASSB = 10, ALU_MUL = 11 … ALU_MULHU = 14, ALU_DIV = 15, ALU_DIVU = 16, ALU_REM = 17, ALU_REMU = 18);
  - the FSM state encodings.
- One sub-module: iter_divider. It owns the FSM, counter, start/done handshake and special-case detection, and reports a done pulse plus result.
- ALU, multiplier and EX/MEM register stay in execute_stage.

Test Plan:
- Reset:
  - Stimulus: drive rst_n = 0 for 2 cycles with a live ADD on the inputs.
  - Required: all EX/MEM outputs are 0 and stall_exe = 0.
- ADD into store:
  - Stimulus: ADD op_a = 0x100, op_b = 0x24, mem_write = 1, w_data = 0xDEADBEEF.
  - Required: next cycle alu_out_exe_mem = 0x124, w_data_exe_mem = 0xDEADBEEF, mem_write = 1.
- Signed divide:
  - Stimulus: DIV op_a = 0xFFFFFF9C (−100), op_b = 7, write_reg = 5.
  - Required: stall_exe is high for exactly 32 cycles and EX/MEM carries bubbles meanwhile.
  - Required: then alu_out = 0xFFFFFFF2 (−14) with write_reg = 5.
  - Stimulus: same operands with REM. Required: alu_out = 0xFFFFFFFE (−2).
- Divide special cases:
  - Stimulus: DIVU 0x1234 / 0. Required: alu_out = 0xFFFFFFFF next cycle, stall_exe never asserts.
  - Stimulus: REM 0x80000000 / 0xFFFFFFFF. Required: alu_out = 0 next cycle.
- MULH:
  - Stimulus: op_a = 0x80000000, op_b = 0x80000000.
  - Required: alu_out = 0x40000000 next cycle.
  - Stimulus: same operands with MULHU. Required: 0x40000000.
  - Stimulus: MULHSU op_a = 0xFFFFFFFF, op_b = 2. Required: 0xFFFFFFFF.
- Flush during divide:
  - Stimulus: start DIVU 1000 / 3, assert flush_exe at BUSY counter 10, then present ADD 1 + 1.
  - Required: stall_exe drops the same cycle and EX/MEM gets a bubble.
  - Required: the ADD then produces alu_out = 2 one cycle later, with no stale quotient ever appearing.
